// File: rtl/thread_cache_pkg.sv
// Shared definitions for the thread cache: FSM encoding, memory latency
// of the companion slow-memory model, and statistics counter helpers.
package thread_cache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_ISSUE = 2'd1,
        RD_WAIT  = 2'd2,
        WR_ISSUE = 2'd3
    } state_t;

    localparam int          WORD     = 16;
    localparam int          MEMDELAY = 4;
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == CNT_MAX) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/thread_cache_rr_arbiter.sv
// Round-robin arbiter: the search starts at ptr, and ptr moves to the slot
// after the winner whenever the grant is taken.
module rr_arbiter
    import thread_cache_pkg::*;
#(
    parameter  int NTHREADS = 2,
    localparam int TIW      = (NTHREADS > 1) ? $clog2(NTHREADS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NTHREADS-1:0] req,
    input  logic                advance,
    output logic                gnt_valid,
    output logic [TIW-1:0]      gnt_idx
);

    logic [TIW-1:0] ptr;

    function automatic logic [TIW-1:0] wrap_add(input logic [TIW-1:0] base, input int offs);
        int sum;
        sum = int'(base) + offs;
        if (sum >= NTHREADS) sum = sum - NTHREADS;
        return TIW'(sum);
    endfunction

    // Scan from farthest to nearest so the slot closest to ptr wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = NTHREADS - 1; i >= 0; i--) begin
            if (req[wrap_add(ptr, i)]) begin
                gnt_valid = 1'b1;
                gnt_idx   = wrap_add(ptr, i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= wrap_add(gnt_idx, 1);
        end
    end

endmodule

// File: rtl/thread_cache.sv
// Direct-mapped, write-through, no-write-allocate cache shared by several
// request threads in front of a slow handshake memory.
//   state    | meaning
//   IDLE     | arbitrate; read hits complete here
//   RD_ISSUE | one-cycle read strobe to memory
//   RD_WAIT  | wait for mem_mfc, then fill and ack
//   WR_ISSUE | one-cycle write strobe, update line on tag hit, ack
module thread_cache
    import thread_cache_pkg::*;
#(
    parameter int NTHREADS = 2,
    parameter int LINES    = 8,
    parameter int AW       = 16,
    parameter int DW       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NTHREADS-1:0]    req_valid,
    input  logic [NTHREADS-1:0]    req_rnotw,
    input  logic [NTHREADS*AW-1:0] req_addr,
    input  logic [NTHREADS*DW-1:0] req_wdata,
    output logic [NTHREADS-1:0]    req_ack,
    output logic [DW-1:0]          rsp_rdata,
    input  logic                   flush,
    output logic                   mem_strobe,
    output logic                   mem_rnotw,
    output logic [AW-1:0]          mem_addr,
    output logic [DW-1:0]          mem_wdata,
    input  logic                   mem_mfc,
    input  logic [DW-1:0]          mem_rdata,
    output logic [15:0]            hit_count,
    output logic [15:0]            miss_count
);

    localparam int IW  = $clog2(LINES);
    localparam int TW  = AW - IW;
    localparam int TIW = $clog2(NTHREADS);

    state_t              state, state_n;
    logic [TIW-1:0]      cur_thr, thr_n;
    logic                gnt_valid, advance;
    logic [TIW-1:0]      gnt_idx;
    logic [NTHREADS-1:0] ack_n;
    logic [DW-1:0]       rdata_n, wdata_n;
    logic                strobe_n, rnotw_n;
    logic [AW-1:0]       addr_n;
    logic [15:0]         hits_n, misses_n;
    logic                fill, wr_upd;

    logic [LINES-1:0]    valid;
    logic [TW-1:0]       tag_mem  [LINES];
    logic [DW-1:0]       data_mem [LINES];

    logic [AW-1:0]       sel_addr;
    logic [DW-1:0]       sel_wdata;
    logic                sel_rnotw, sel_hit, cur_hit;
    logic [IW-1:0]       sel_idx, cur_idx;

    // A thread whose ack is showing still holds req_valid; keep it out.
    rr_arbiter #(.NTHREADS(NTHREADS)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid & ~req_ack),
        .advance   (advance),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx)
    );

    assign sel_addr  = req_addr[gnt_idx*AW +: AW];
    assign sel_wdata = req_wdata[gnt_idx*DW +: DW];
    assign sel_rnotw = req_rnotw[gnt_idx];
    assign sel_idx   = sel_addr[IW-1:0];
    assign sel_hit   = valid[sel_idx] && (tag_mem[sel_idx] == sel_addr[AW-1:IW]);
    assign cur_idx   = mem_addr[IW-1:0];
    assign cur_hit   = valid[cur_idx] && (tag_mem[cur_idx] == mem_addr[AW-1:IW]);

    always_comb begin
        state_n  = state;
        thr_n    = cur_thr;
        ack_n    = '0;
        rdata_n  = rsp_rdata;
        strobe_n = 1'b0;
        rnotw_n  = mem_rnotw;
        addr_n   = mem_addr;
        wdata_n  = mem_wdata;
        hits_n   = hit_count;
        misses_n = miss_count;
        advance  = 1'b0;
        fill     = 1'b0;
        wr_upd   = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    advance = 1'b1;
                    thr_n   = gnt_idx;
                    if (sel_rnotw && sel_hit) begin
                        ack_n[gnt_idx] = 1'b1;
                        rdata_n        = data_mem[sel_idx];
                        hits_n         = sat_inc(hit_count);
                    end else if (sel_rnotw) begin
                        state_n  = RD_ISSUE;
                        strobe_n = 1'b1;
                        rnotw_n  = 1'b1;
                        addr_n   = sel_addr;
                    end else begin
                        state_n  = WR_ISSUE;
                        strobe_n = 1'b1;
                        rnotw_n  = 1'b0;
                        addr_n   = sel_addr;
                        wdata_n  = sel_wdata;
                    end
                end
            end
            RD_ISSUE: state_n = RD_WAIT;
            RD_WAIT: begin
                if (mem_mfc) begin
                    fill           = 1'b1;
                    ack_n[cur_thr] = 1'b1;
                    rdata_n        = mem_rdata;
                    misses_n       = sat_inc(miss_count);
                    state_n        = IDLE;
                end
            end
            WR_ISSUE: begin
                wr_upd         = cur_hit;
                ack_n[cur_thr] = 1'b1;
                state_n        = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cur_thr    <= '0;
            req_ack    <= '0;
            rsp_rdata  <= '0;
            mem_strobe <= 1'b0;
            mem_rnotw  <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            hit_count  <= '0;
            miss_count <= '0;
            valid      <= '0;
        end else begin
            state      <= state_n;
            cur_thr    <= thr_n;
            req_ack    <= ack_n;
            rsp_rdata  <= rdata_n;
            mem_strobe <= strobe_n;
            mem_rnotw  <= rnotw_n;
            mem_addr   <= addr_n;
            mem_wdata  <= wdata_n;
            hit_count  <= hits_n;
            miss_count <= misses_n;
            // Flush wins over a coincident fill, leaving that line invalid.
            if (flush) begin
                valid <= '0;
            end else if (fill) begin
                valid[cur_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_mem[cur_idx]  <= mem_addr[AW-1:IW];
            data_mem[cur_idx] <= mem_rdata;
        end else if (wr_upd) begin
            data_mem[cur_idx] <= mem_wdata;
        end
    end

endmodule

// File: tb/tb_thread_cache.sv
// Directed bench for thread_cache with a slow-memory model; expected acks
// are queued at issue time and checked by an independent monitor.
module tb_thread_cache;
    import thread_cache_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_rnotw = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [1:0]  req_ack;
    logic [15:0] rsp_rdata;
    logic        flush = 1'b0;
    logic        mem_strobe, mem_rnotw;
    logic [15:0] mem_addr, mem_wdata;
    logic        mem_mfc;
    logic [15:0] mem_rdata;
    logic [15:0] hit_count, miss_count;

    thread_cache #(.NTHREADS(2), .LINES(8), .AW(16), .DW(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_rnotw  (req_rnotw),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ack    (req_ack),
        .rsp_rdata  (rsp_rdata),
        .flush      (flush),
        .mem_strobe (mem_strobe),
        .mem_rnotw  (mem_rnotw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_mfc    (mem_mfc),
        .mem_rdata  (mem_rdata),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          thr;
        bit          rd;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_rd_strobe = 0;
    int   n_wr_strobe = 0;
    int   n_mfc = 0;
    int   rd0, wr0, mfc0;
    bit   got, fl_seen;

    // Slow memory: read data returns MEMDELAY cycles after the strobe is seen.
    logic [15:0]  wdat [0:255];
    logic [255:0] wvalid = '0;
    logic         sm_mfc = 1'b0;
    logic         stray_mfc = 1'b0;
    logic [15:0]  sm_rdata = '0;
    logic [7:0]   sm_addr = '0;
    int           sm_dly = 0;
    bit           sm_pend = 1'b0;
    logic [15:0]  last_waddr = '0;
    logic [15:0]  last_wdata = '0;

    assign mem_mfc   = sm_mfc | stray_mfc;
    assign mem_rdata = sm_rdata;

    function automatic logic [15:0] dflt(input logic [7:0] a);
        return (a == 8'h03) ? 16'hBEEF : {a, ~a};
    endfunction

    always @(posedge clk) begin
        sm_mfc <= 1'b0;
        if (mem_strobe && mem_rnotw) begin
            sm_pend <= 1'b1;
            sm_dly  <= MEMDELAY;
            sm_addr <= mem_addr[7:0];
        end else if (sm_pend) begin
            if (sm_dly == 1) begin
                sm_pend  <= 1'b0;
                sm_mfc   <= 1'b1;
                sm_rdata <= wvalid[sm_addr] ? wdat[sm_addr] : dflt(sm_addr);
            end else begin
                sm_dly <= sm_dly - 1;
            end
        end
        if (mem_strobe && !mem_rnotw) begin
            wvalid[mem_addr[7:0]] <= 1'b1;
            wdat[mem_addr[7:0]]   <= mem_wdata;
            last_waddr            <= mem_addr;
            last_wdata            <= mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every ack pops one expectation in order.
    initial begin
        forever begin
            @(negedge clk);
            if (mem_strobe && mem_rnotw) n_rd_strobe++;
            if (mem_strobe && !mem_rnotw) n_wr_strobe++;
            if (sm_mfc) n_mfc++;
            if (req_ack != 2'b00) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_ack: got %b, expected none", req_ack);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("ack_thread", {30'd0, req_ack}, 32'd1 << e.thr);
                    if (e.rd) check("rsp_rdata", {16'd0, rsp_rdata}, {16'd0, e.data});
                end
            end
        end
    end

    task automatic expect_ack(input int t, input bit rd, input logic [15:0] d);
        sb.push_back('{thr: t, rd: rd, data: d});
    endtask

    task automatic do_req(input int t, input bit rd, input logic [15:0] addr,
                          input logic [15:0] wd, input int exp_lat);
        int  lat;
        bit  seen;
        @(negedge clk);
        req_rnotw[t]          = rd;
        req_addr[t*16 +: 16]  = addr;
        req_wdata[t*16 +: 16] = wd;
        req_valid[t]          = 1'b1;
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (req_ack[t]) seen = 1'b1;
        end
        req_valid[t] = 1'b0;
        if (!seen) check("ack_timeout", 32'd0, 32'd1);
        else if (exp_lat != 0) check("ack_latency", lat, exp_lat);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_req_ack", req_ack, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_mem_strobe", mem_strobe, 0);
        check("rst_mem_rnotw", mem_rnotw, 1);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);
        reset = 1'b1;

        // Cold read miss, then repeat hit.
        rd0 = n_rd_strobe;
        expect_ack(0, 1'b1, 16'hBEEF);
        do_req(0, 1'b1, 16'h0003, 16'h0, 7);
        check("cold_miss_count", miss_count, 1);
        check("cold_rd_strobes", n_rd_strobe - rd0, 1);
        rd0 = n_rd_strobe;
        expect_ack(0, 1'b1, 16'hBEEF);
        do_req(0, 1'b1, 16'h0003, 16'h0, 1);
        check("hit_count_1", hit_count, 1);
        check("hit_no_strobe", n_rd_strobe - rd0, 0);

        // Write-through to a cached line, then hit on the new data.
        wr0 = n_wr_strobe;
        rd0 = n_rd_strobe;
        expect_ack(0, 1'b0, 16'h0);
        do_req(0, 1'b0, 16'h0003, 16'h1234, 2);
        check("wr_strobes", n_wr_strobe - wr0, 1);
        check("wr_no_rd_strobe", n_rd_strobe - rd0, 0);
        check("wr_mem_addr", last_waddr, 16'h0003);
        check("wr_mem_data", last_wdata, 16'h1234);
        expect_ack(0, 1'b1, 16'h1234);
        do_req(0, 1'b1, 16'h0003, 16'h0, 1);
        check("hit_count_2", hit_count, 2);

        // Index 3 aliasing: addr 11 evicts addr 3.
        expect_ack(0, 1'b1, 16'h0BF4);
        do_req(0, 1'b1, 16'h000B, 16'h0, 7);
        expect_ack(0, 1'b1, 16'h1234);
        do_req(0, 1'b1, 16'h0003, 16'h0, 7);
        check("evict_miss_count", miss_count, 3);
        check("evict_hit_count", hit_count, 2);

        // Round-robin: pointer 0 after reset, then forced to 1 by a lone thread-0 grant.
        apply_reset();
        check("rst2_miss_count", miss_count, 0);
        expect_ack(0, 1'b1, 16'h05FA);
        expect_ack(1, 1'b1, 16'h06F9);
        fork
            do_req(0, 1'b1, 16'h0005, 16'h0, 0);
            do_req(1, 1'b1, 16'h0006, 16'h0, 0);
        join
        expect_ack(0, 1'b1, 16'h05FA);
        do_req(0, 1'b1, 16'h0005, 16'h0, 1);
        expect_ack(1, 1'b1, 16'h06F9);
        expect_ack(0, 1'b1, 16'h05FA);
        fork
            do_req(0, 1'b1, 16'h0005, 16'h0, 2);
            do_req(1, 1'b1, 16'h0006, 16'h0, 1);
        join
        check("rr_miss_count", miss_count, 2);
        check("rr_hit_count", hit_count, 3);

        // Reset while waiting for memory: no ack, late mfc ignored.
        @(negedge clk);
        req_rnotw[0]      = 1'b1;
        req_addr[15:0]    = 16'h0007;
        req_valid[0]      = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (mem_strobe) got = 1'b1;
        end
        check("midmiss_strobe_seen", got, 1);
        @(negedge clk);
        mfc0 = n_mfc;
        #1 reset = 1'b0;
        #1;
        check("midrst_req_ack", req_ack, 0);
        check("midrst_rsp_rdata", rsp_rdata, 0);
        check("midrst_mem_strobe", mem_strobe, 0);
        check("midrst_mem_rnotw", mem_rnotw, 1);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_hit_count", hit_count, 0);
        check("midrst_miss_count", miss_count, 0);
        req_valid[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (8) @(negedge clk);
        check("late_mfc_arrived", n_mfc - mfc0, 1);
        check("late_mfc_no_fill", miss_count, 0);
        expect_ack(0, 1'b1, 16'h07F8);
        do_req(0, 1'b1, 16'h0007, 16'h0, 7);
        check("post_rst_miss", miss_count, 1);

        // Stray mfc while idle must be ignored.
        @(negedge clk);
        stray_mfc = 1'b1;
        @(negedge clk);
        stray_mfc = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_no_strobe", mem_strobe, 0);
        check("stray_miss_count", miss_count, 1);
        expect_ack(0, 1'b1, 16'h07F8);
        do_req(0, 1'b1, 16'h0007, 16'h0, 1);
        check("stray_hit_count", hit_count, 1);

        // Flush on the fill cycle: data still delivered, line stays invalid.
        fl_seen = 1'b0;
        expect_ack(0, 1'b1, 16'h09F6);
        fork
            do_req(0, 1'b1, 16'h0009, 16'h0, 7);
            begin
                for (int i = 0; i < 30 && !fl_seen; i++) begin
                    @(negedge clk);
                    if (mem_mfc) fl_seen = 1'b1;
                end
                if (fl_seen) begin
                    flush = 1'b1;
                    @(negedge clk);
                    flush = 1'b0;
                end
            end
        join
        check("flush_hit_fill", fl_seen, 1);
        expect_ack(0, 1'b1, 16'h09F6);
        do_req(0, 1'b1, 16'h0009, 16'h0, 7);
        expect_ack(0, 1'b1, 16'h07F8);
        do_req(0, 1'b1, 16'h0007, 16'h0, 7);
        check("flush_miss_count", miss_count, 4);
        check("flush_hit_count", hit_count, 1);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
